// File: rtl/traffic_signal_monitor.sv
// ---------------------------------------------------------------------------
// traffic_signal_monitor : checks two-direction lamp outputs for conflicts,
//                          illegal sequences and dwell-time violations
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module traffic_signal_monitor #(
  parameter int CNT_W   = 8,
  parameter int MIN_GRN = 4,
  parameter int MIN_YLW = 2,
  parameter int MAX_YLW = 6
) (
  input  logic       CK,
  input  logic       CLR,
  input  logic       GRN1,
  input  logic       YLW1,
  input  logic       RED1,
  input  logic       GRN2,
  input  logic       YLW2,
  input  logic       RED2,
  output logic [1:0] PH1,
  output logic [1:0] PH2,
  output logic       FAULT,
  output logic [2:0] FCODE,
  output logic       FDIR,
  output logic       FLASH
);

  localparam logic [1:0] C_PH_RED = 2'd0;
  localparam logic [1:0] C_PH_GRN = 2'd1;
  localparam logic [1:0] C_PH_YLW = 2'd2;

  localparam logic [1:0] C_ST_ARM  = 2'd0;
  localparam logic [1:0] C_ST_RUN  = 2'd1;
  localparam logic [1:0] C_ST_TRIP = 2'd2;

  localparam logic [2:0] C_F_NONE     = 3'd0;
  localparam logic [2:0] C_F_CONFLICT = 3'd1;
  localparam logic [2:0] C_F_ILLEGAL  = 3'd2;
  localparam logic [2:0] C_F_SHORTG   = 3'd3;
  localparam logic [2:0] C_F_SHORTY   = 3'd4;
  localparam logic [2:0] C_F_LONGY    = 3'd5;
  localparam logic [2:0] C_F_LAMP     = 3'd6;

  localparam logic [CNT_W-1:0] C_DWELL_SAT = '1;
  localparam logic [CNT_W-1:0] C_DWELL_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MIN_GRN   = CNT_W'(MIN_GRN);
  localparam logic [CNT_W-1:0] C_MIN_YLW   = CNT_W'(MIN_YLW);
  localparam logic [CNT_W-1:0] C_MAX_YLW   = CNT_W'(MAX_YLW);

  logic [2:0]       r_lamp  [2];   // {grn, ylw, red}
  logic             r_s_vld;       // S stage holds a real sample (not reset zeros)
  logic [1:0]       r_ph    [2];
  logic [CNT_W-1:0] r_dwell [2];
  logic [1:0]       r_seen;
  logic [1:0]       r_inv;
  logic [1:0]       r_state;
  logic             r_fault;
  logic [2:0]       r_fcode;
  logic             r_fdir;

  logic [1:0]       w_vld;
  logic [1:0]       w_inv;
  logic [1:0]       w_ph_dec    [2];
  logic [1:0]       w_ph_nxt    [2];
  logic [CNT_W-1:0] w_dwell_nxt [2];
  logic [2:0]       w_code      [2];
  logic             w_run;
  logic             w_conf;
  logic [2:0]       w_sel_code;
  logic             w_sel_dir;

  assign w_run = (r_state == C_ST_RUN);

  generate
    for (genvar d = 0; d < 2; d++) begin : g_dir
      logic w_chg;
      logic w_legal;
      logic w_ill;
      logic w_sg;
      logic w_sy;
      logic w_ly;
      logic w_lampf;
      logic [CNT_W-1:0] w_inc;

      assign w_vld[d] = r_s_vld && ((r_lamp[d] == 3'b100) || (r_lamp[d] == 3'b010) ||
                                    (r_lamp[d] == 3'b001));
      assign w_inv[d] = r_s_vld && !w_vld[d];
      assign w_ph_dec[d] = r_lamp[d][2] ? C_PH_GRN : (r_lamp[d][1] ? C_PH_YLW : C_PH_RED);
      assign w_chg = w_vld[d] && r_seen[d] && (w_ph_dec[d] != r_ph[d]);

      assign w_legal = ((r_ph[d] == C_PH_RED) && (w_ph_dec[d] == C_PH_GRN)) ||
                       ((r_ph[d] == C_PH_GRN) && (w_ph_dec[d] == C_PH_YLW)) ||
                       ((r_ph[d] == C_PH_YLW) && (w_ph_dec[d] == C_PH_RED));

      assign w_inc = (r_dwell[d] == C_DWELL_SAT) ? r_dwell[d] : r_dwell[d] + C_DWELL_ONE;
      assign w_ph_nxt[d] = w_vld[d] ? w_ph_dec[d] : r_ph[d];
      // First valid sample or a phase change restarts the dwell count
      assign w_dwell_nxt[d] = (w_vld[d] && (!r_seen[d] || w_chg)) ? C_DWELL_ONE :
                              (r_s_vld ? w_inc : r_dwell[d]);

      assign w_ill   = w_chg && !w_legal;
      assign w_sg    = w_chg && w_legal && (r_ph[d] == C_PH_GRN) && (r_dwell[d] < C_MIN_GRN);
      assign w_sy    = w_chg && w_legal && (r_ph[d] == C_PH_YLW) && (r_dwell[d] < C_MIN_YLW);
      assign w_ly    = r_s_vld && (w_ph_nxt[d] == C_PH_YLW) && (w_dwell_nxt[d] >= C_MAX_YLW);
      assign w_lampf = w_inv[d] && r_inv[d];

      assign w_code[d] = (w_run && w_ill) ? C_F_ILLEGAL :
                         (w_run && w_sg)  ? C_F_SHORTG  :
                         (w_run && w_sy)  ? C_F_SHORTY  :
                         (w_run && w_ly)  ? C_F_LONGY   :
                         w_lampf          ? C_F_LAMP    : C_F_NONE;
    end
  endgenerate

  assign w_conf = w_vld[0] && w_vld[1] && (w_ph_dec[0] != C_PH_RED) && (w_ph_dec[1] != C_PH_RED);

  // Lowest code wins; direction 1 wins ties
  always_comb begin
    w_sel_code = C_F_NONE;
    w_sel_dir  = 1'b0;
    if (w_conf) begin
      w_sel_code = C_F_CONFLICT;
    end else if ((w_code[0] != C_F_NONE) && ((w_code[1] == C_F_NONE) || (w_code[0] <= w_code[1]))) begin
      w_sel_code = w_code[0];
    end else if (w_code[1] != C_F_NONE) begin
      w_sel_code = w_code[1];
      w_sel_dir  = 1'b1;
    end
  end

  always_ff @(posedge CK) begin
    if (CLR) begin
      for (int d = 0; d < 2; d++) begin
        r_lamp[d]  <= 3'b000;
        r_ph[d]    <= C_PH_RED;
        r_dwell[d] <= '0;
      end
      r_s_vld <= 1'b0;
      r_seen  <= 2'b00;
      r_inv   <= 2'b00;
      r_state <= C_ST_ARM;
      r_fault <= 1'b0;
      r_fcode <= C_F_NONE;
      r_fdir  <= 1'b0;
    end else begin
      r_lamp[0] <= {GRN1, YLW1, RED1};
      r_lamp[1] <= {GRN2, YLW2, RED2};
      r_s_vld   <= 1'b1;
      for (int d = 0; d < 2; d++) begin
        r_ph[d]    <= w_ph_nxt[d];
        r_dwell[d] <= w_dwell_nxt[d];
      end
      r_seen <= r_seen | w_vld;
      r_inv  <= w_inv;
      case (r_state)
        C_ST_ARM, C_ST_RUN: begin
          if (w_sel_code != C_F_NONE) begin
            r_state <= C_ST_TRIP;
            r_fault <= 1'b1;
            r_fcode <= w_sel_code;
            r_fdir  <= w_sel_dir;
          end else if ((r_state == C_ST_ARM) && (&(r_seen | w_vld))) begin
            r_state <= C_ST_RUN;
          end
        end
        default: r_state <= C_ST_TRIP;
      endcase
    end
  end

  assign PH1   = r_ph[0];
  assign PH2   = r_ph[1];
  assign FAULT = r_fault;
  assign FCODE = r_fcode;
  assign FDIR  = r_fdir;
  assign FLASH = r_fault;

endmodule

`default_nettype wire
